// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared framebuffer geometry, pixel entry layout and write FSM encoding
package vga_pkg;

    localparam int FB_ADDR_W = 18;
    localparam int FB_X_BITS = 9;

    // RGB 3-3-2 layout: red [7:5], blue [4:2], green [1:0]
    typedef struct packed {
        logic [2:0] red;
        logic [2:0] blue;
        logic [1:0] green;
    } rgb332_t;

    typedef struct packed {
        logic [FB_X_BITS-1:0] y;
        logic [FB_X_BITS-1:0] x;
        rgb332_t              color;
    } px_entry_t;

    localparam int PX_W = $bits(px_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } wr_state_t;

endpackage

// File: rtl/vga_px_fifo.sv
// rtl/vga_px_fifo.sv - pixel request FIFO, synchronous reset, refuses pushes while full
module vga_px_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vga_fb_writer.sv
// rtl/vga_fb_writer.sv - queues pixel writes and full-frame clears into a shared framebuffer SRAM
module vga_fb_writer
    import vga_pkg::*;
#(
    parameter int FB_HEIGHT  = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 display_enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9:0]           in_x,
    input  logic [9:0]           in_y,
    input  logic [7:0]           in_color,
    input  logic                 clear_start,
    input  logic [7:0]           clear_color,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [7:0]           mem_data,
    output logic                 mem_wr_enable,
    output logic                 chip_enable,
    output logic                 busy,
    output logic                 drop_pulse
);
    localparam logic [FB_ADDR_W-1:0] CLEAR_LAST = FB_ADDR_W'((1 << FB_X_BITS) * FB_HEIGHT - 1);

    wr_state_t            r_state;
    logic [FB_ADDR_W-1:0] r_mem_addr;
    logic [7:0]           r_mem_data;
    logic                 r_mem_wr;
    logic                 r_cs;
    logic                 r_busy;
    logic                 r_drop;
    logic                 r_cur_clear;
    logic                 r_clear_active;
    logic [FB_ADDR_W-1:0] r_clear_addr;
    logic [7:0]           r_clear_color;

    logic                 w_full;
    logic                 w_empty;
    logic [PX_W-1:0]      w_head;
    px_entry_t            w_head_px;
    px_entry_t            w_push_px;
    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_clear_go;
    logic [FB_ADDR_W-1:0] w_clear_addr;
    logic [7:0]           w_clear_color;

    assign in_ready   = !w_full && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_in_range = !in_x[9] && (32'(in_y) < FB_HEIGHT);
    assign w_push     = w_accept && w_in_range;
    assign w_push_px  = {in_y[FB_X_BITS-1:0], in_x[FB_X_BITS-1:0], in_color};
    assign w_head_px  = w_head;
    assign w_pop      = (r_state == ST_SETUP) && !display_enable && !r_cur_clear;

    // A clear_start seen this cycle already counts as the active clear when choosing the next job
    assign w_clear_go    = clear_start || r_clear_active;
    assign w_clear_addr  = clear_start ? '0 : r_clear_addr;
    assign w_clear_color = clear_start ? clear_color : r_clear_color;

    vga_px_fifo #(
        .WIDTH (PX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_px),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_mem_addr     <= '0;
            r_mem_data     <= '0;
            r_mem_wr       <= 1'b0;
            r_cs           <= 1'b0;
            r_busy         <= 1'b0;
            r_drop         <= 1'b0;
            r_cur_clear    <= 1'b0;
            r_clear_active <= 1'b0;
            r_clear_addr   <= '0;
            r_clear_color  <= '0;
        end else begin
            r_drop   <= w_accept && !w_in_range;
            r_busy   <= w_push || !w_empty || (r_state != ST_IDLE) || w_clear_go;
            r_mem_wr <= 1'b0;

            // Counter advances only when a clear write commits to its strobe
            if (clear_start) begin
                r_clear_active <= 1'b1;
                r_clear_addr   <= '0;
                r_clear_color  <= clear_color;
            end else if (r_state == ST_SETUP && !display_enable && r_cur_clear && r_clear_active) begin
                if (r_clear_addr == CLEAR_LAST) r_clear_active <= 1'b0;
                else                            r_clear_addr   <= r_clear_addr + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cs <= 1'b0;
                    if (!display_enable && w_clear_go) begin
                        r_state     <= ST_SETUP;
                        r_cs        <= 1'b1;
                        r_cur_clear <= 1'b1;
                        r_mem_addr  <= w_clear_addr;
                        r_mem_data  <= w_clear_color;
                    end else if (!display_enable && !w_empty) begin
                        r_state     <= ST_SETUP;
                        r_cs        <= 1'b1;
                        r_cur_clear <= 1'b0;
                        r_mem_addr  <= {w_head_px.y, w_head_px.x};
                        r_mem_data  <= w_head_px.color;
                    end
                end
                ST_SETUP: begin
                    if (display_enable) begin
                        r_state <= ST_IDLE;
                        r_cs    <= 1'b0;
                    end else begin
                        r_state  <= ST_STROBE;
                        r_mem_wr <= 1'b1;
                    end
                end
                ST_STROBE: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!display_enable && !w_clear_go && !w_empty) begin
                        r_state     <= ST_SETUP;
                        r_cur_clear <= 1'b0;
                        r_mem_addr  <= {w_head_px.y, w_head_px.x};
                        r_mem_data  <= w_head_px.color;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cs    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_data      = r_mem_data;
    assign mem_wr_enable = r_mem_wr;
    assign chip_enable   = r_cs;
    assign busy          = r_busy;
    assign drop_pulse    = r_drop;

endmodule
